// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue
// In-order (pc, instruction) buffer between the fetch and decode stages.
// Decode sees a NOP bubble whenever the queue is empty. Freeze holds the head
// entry while fetch keeps filling the queue. Flush drops every entry on a
// redirect.
module if_id_fetch_queue #(
   parameter int             N     = 32,
   parameter int             DEPTH = 4,
   parameter logic [N-1:0]   NOP   = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       freeze,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N-1:0]               in_pc,
   input  logic [N-1:0]               in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N-1:0]               out_pc,
   output logic [N-1:0]               out_instr,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Storage has no reset. The count gates every read, so stale contents are never seen.
   logic [N-1:0]  r_mem_pc    [DEPTH];
   logic [N-1:0]  r_mem_instr [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_next;

   // Handshake qualification.
   // in_ready depends only on registered state, so a full queue refuses a push
   // even when a pop happens in the same cycle. Flush suppresses both push and pop.
   always_comb begin
      w_in_ready   = (r_count != FULL_CNT);
      w_out_valid  = (r_count != '0);
      w_push       = in_valid & w_in_ready & ~flush;
      w_pop        = w_out_valid & out_ready & ~freeze & ~flush;
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
   end

   // Pointer and occupancy state. Flush clears everything at the next edge.
   // DEPTH is a power of two, so the pointers wrap naturally at DEPTH-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_next;
      end
   end

   // Entry write. Only accepted pushes land in the array.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]    <= in_pc;
         r_mem_instr[r_wr_ptr] <= in_instr;
      end
   end

   // Head presentation comes from registered storage only, with no fall-through
   // from the input. An empty queue shows pc 0 and a NOP bubble.
   always_comb begin
      in_ready  = w_in_ready;
      out_valid = w_out_valid;
      count     = r_count;
      out_pc    = '0;
      out_instr = NOP;
      if (w_out_valid) begin
         out_pc    = r_mem_pc[r_rd_ptr];
         out_instr = r_mem_instr[r_rd_ptr];
      end
   end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb_if_id_fetch_queue
// Directed bench for the IF/ID fetch queue with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_if_id_fetch_queue;

   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          freeze;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_pc;
   logic [N-1:0]  in_instr;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_pc;
   logic [N-1:0]  out_instr;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_errors = 0;

   if_id_fetch_queue #(.N(N), .DEPTH(DEPTH), .NOP('0)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .freeze    (freeze),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Instruction word paired with each pc: 0x0->0x13, 0x4->0x93, 0x8->0x113, 0xC->0x193.
   function automatic logic [N-1:0] instr_of(input logic [N-1:0] pc);
      return (pc << 5) + 32'h13;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [N-1:0] pc);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr_of(pc);
   endtask

   task automatic head_is(input string tag, input logic [N-1:0] pc);
      check({tag, ".valid"}, 64'(out_valid), 64'(1));
      check({tag, ".pc"},    64'(out_pc),    64'(pc));
      check({tag, ".instr"}, 64'(out_instr), 64'(instr_of(pc)));
   endtask

   task automatic empty_is(input string tag);
      check({tag, ".valid"}, 64'(out_valid), 64'(0));
      check({tag, ".pc"},    64'(out_pc),    64'(0));
      check({tag, ".instr"}, 64'(out_instr), 64'(0));
      check({tag, ".count"}, 64'(count),     64'(0));
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      freeze    = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      out_ready = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      empty_is("reset");
      check("reset.in_ready", 64'(in_ready), 64'(1));

      // Async reset in the middle of a cycle with three entries stored.
      for (int i = 0; i < 3; i++) begin
         offer(32'(i * 4));
         cyc();
      end
      in_valid = 1'b0;
      check("t1.count3", 64'(count), 64'(3));
      head_is("t1.head", 32'h0);
      #2;
      rst = 1'b1;
      #1;
      empty_is("t1.rst");
      check("t1.in_ready", 64'(in_ready), 64'(1));
      rst = 1'b0;
      cyc();
      empty_is("t1.after");

      // Fill to full, refuse a fifth push, then drain in order.
      for (int i = 0; i < 4; i++) begin
         offer(32'(i * 4));
         if (i == 0) empty_is("t2.latency");
         cyc();
         check($sformatf("t2.fill%0d", i), 64'(count), 64'(i + 1));
      end
      check("t2.full.in_ready", 64'(in_ready), 64'(0));
      offer(32'h10);
      cyc();
      in_valid = 1'b0;
      check("t2.push_ignored", 64'(count), 64'(4));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         head_is($sformatf("t2.pop%0d", i), 32'(i * 4));
         cyc();
      end
      out_ready = 1'b0;
      empty_is("t2.drained");

      // Steady push+pop at count 1; pointers wrap several times.
      offer(32'h100);
      cyc();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         offer(32'h104 + 32'(i * 4));
         head_is($sformatf("t3.s%0d", i), 32'h100 + 32'(i * 4));
         check($sformatf("t3.count%0d", i), 64'(count), 64'(1));
         cyc();
      end
      in_valid = 1'b0;
      head_is("t3.last", 32'h128);
      cyc();
      out_ready = 1'b0;
      empty_is("t3.drained");

      // Freeze holds the head while the queue fills.
      offer(32'h300);
      cyc();
      offer(32'h304);
      cyc();
      freeze    = 1'b1;
      out_ready = 1'b1;
      offer(32'h308);
      cyc();
      head_is("t4.frz1", 32'h300);
      offer(32'h30C);
      cyc();
      head_is("t4.frz2", 32'h300);
      check("t4.count", 64'(count), 64'(4));
      check("t4.in_ready", 64'(in_ready), 64'(0));
      // Unfreeze while full with a push offered: pop only, push dropped.
      freeze = 1'b0;
      offer(32'h310);
      head_is("t4.resume", 32'h300);
      cyc();
      in_valid = 1'b0;
      check("t4.no_passthru", 64'(count), 64'(3));
      for (int i = 1; i < 4; i++) begin
         head_is($sformatf("t4.pop%0d", i), 32'h300 + 32'(i * 4));
         cyc();
      end
      out_ready = 1'b0;
      empty_is("t4.drained");

      // Flush beats freeze and a same-cycle push.
      for (int i = 0; i < 3; i++) begin
         offer(32'h400 + 32'(i * 4));
         cyc();
      end
      check("t5.count3", 64'(count), 64'(3));
      flush     = 1'b1;
      freeze    = 1'b1;
      out_ready = 1'b1;
      offer(32'h40C);
      cyc();
      flush    = 1'b0;
      freeze   = 1'b0;
      in_valid = 1'b0;
      empty_is("t5.flushed");
      check("t5.in_ready", 64'(in_ready), 64'(1));
      out_ready = 1'b0;
      offer(32'h200);
      empty_is("t5.prepush");
      cyc();
      in_valid = 1'b0;
      head_is("t5.newhead", 32'h200);
      check("t5.count1", 64'(count), 64'(1));
      out_ready = 1'b1;
      cyc();
      empty_is("t5.drained");

      // Empty queue ignores out_ready.
      for (int i = 0; i < 5; i++) begin
         cyc();
         empty_is($sformatf("t6.c%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
